// File: rtl/temp_pkg.sv
// rtl/temp_pkg.sv - shared state type, widths and conditioning rule for temp_read_sched
// Averaging (TEMP_SCHED_AVG_EN) is selected in the top; nothing here depends on it.
package temp_pkg;
  localparam int TEMP_W = 16;
  localparam int HALF_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_LATCH, ST_WAIT} state_t;

  // raw_hi is rd_data[15:7]; negative readings clamp to zero half-degrees
  function automatic logic [HALF_W-1:0] condition_raw(input logic [8:0] raw_hi);
    condition_raw = raw_hi[8] ? '0 : raw_hi[7:0];
  endfunction
endpackage

// File: rtl/temp_avg4.sv
// rtl/temp_avg4.sv - 4-entry moving-average window of half-degree values
// Used only when TEMP_SCHED_AVG_EN is defined; the first push fills every entry.
module temp_avg4 import temp_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [HALF_W-1:0] i_value,
  output logic [HALF_W-1:0] o_avg
);
  logic [HALF_W-1:0] r_win [4];
  logic              r_filled;
  logic [HALF_W+1:0] w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_win[i] <= '0;
      r_filled <= 1'b0;
    end else if (i_push) begin
      if (!r_filled) begin
        for (int i = 0; i < 4; i++) r_win[i] <= i_value;
        r_filled <= 1'b1;
      end else begin
        r_win[0] <= i_value;
        r_win[1] <= r_win[0];
        r_win[2] <= r_win[1];
        r_win[3] <= r_win[2];
      end
    end
  end

  assign w_sum = {2'b00, r_win[0]} + {2'b00, r_win[1]} + {2'b00, r_win[2]} + {2'b00, r_win[3]};
  assign o_avg = w_sum[HALF_W+1:2];
endmodule

// File: rtl/temp_read_sched.sv
// rtl/temp_read_sched.sv - periodic temperature read scheduler with timeout and conditioning
// Define TEMP_SCHED_AVG_EN to output a 4-sample moving average instead of the latest sample.
module temp_read_sched import temp_pkg::*; #(
  parameter logic [31:0] SAMPLE_DIV = 32'd50000000,
  parameter logic [15:0] TIMEOUT    = 16'd1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              rd_req,
  input  logic              rd_ack,
  input  logic [TEMP_W-1:0] rd_data,
  output logic [TEMP_W-1:0] data_out,
  output logic              data_valid,
  output logic              timeout_err,
  output logic              neg_flag,
  output logic [7:0]        sample_cnt,
  output logic              busy
);
  localparam logic [31:0] L_WAIT_LAST = SAMPLE_DIV - 32'd1;
  localparam logic [31:0] L_TO_LAST   = {16'd0, TIMEOUT} - 32'd1;

  state_t            r_state, w_next;
  logic [31:0]       r_cnt;
  logic              w_accept, w_timeout;
  logic [HALF_W-1:0] w_cond, w_value;
  logic              r_neg_cap, r_neg, r_valid, r_err;
  logic [TEMP_W-1:0] r_dout;
  logic [7:0]        r_samples;
  logic              w_unused_bits;

  assign w_unused_bits = &{1'b0, rd_data[6:0]};
  assign w_cond        = condition_raw(rd_data[15:7]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Ack is tested before the timeout so a same-cycle ack always wins
  always_comb begin
    w_next    = r_state;
    rd_req    = 1'b0;
    busy      = 1'b1;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (enable) w_next = ST_REQ;
      end
      ST_REQ: begin
        rd_req = 1'b1;
        if (rd_ack) begin
          w_accept = 1'b1;
          w_next   = ST_LATCH;
        end else if (r_cnt == L_TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = enable ? ST_WAIT : ST_IDLE;
        end
      end
      ST_LATCH: w_next = enable ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!enable)                  w_next = ST_IDLE;
        else if (r_cnt == L_WAIT_LAST) w_next = ST_REQ;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // One counter serves both the REQ timeout and the WAIT interval
  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state) || (r_state == ST_IDLE)) r_cnt <= '0;
    else                                                     r_cnt <= r_cnt + 32'd1;
  end

`ifdef TEMP_SCHED_AVG_EN
  temp_avg4 u_avg (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_value (w_cond),
    .o_avg   (w_value)
  );
`else
  logic [HALF_W-1:0] r_value;
  always_ff @(posedge clk) begin
    if (rst)           r_value <= '0;
    else if (w_accept) r_value <= w_cond;
  end
  assign w_value = r_value;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_cap <= 1'b0;
      r_neg     <= 1'b0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_samples <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept)  r_neg_cap <= rd_data[15];
      if (w_timeout) r_err     <= 1'b1;
      if (r_state == ST_LATCH) begin
        r_dout    <= {1'b0, w_value, 7'b0};
        r_valid   <= 1'b1;
        r_samples <= r_samples + 8'd1;
        r_err     <= 1'b0;
        r_neg     <= r_neg_cap;
      end
    end
  end

  assign data_out    = r_dout;
  assign data_valid  = r_valid;
  assign timeout_err = r_err;
  assign neg_flag    = r_neg;
  assign sample_cnt  = r_samples;
endmodule

// File: tb/tb_temp_read_sched.sv
// tb/tb_temp_read_sched.sv - self-checking bench for temp_read_sched (SAMPLE_DIV=8, TIMEOUT=4)
// Expected literals switch with TEMP_SCHED_AVG_EN to match the averaging build.
`timescale 1ns/1ps
module tb_temp_read_sched;
  localparam int TO = 4;

`ifdef TEMP_SCHED_AVG_EN
  localparam logic [15:0] EXP_S2 = 16'h1300;
  localparam logic [15:0] EXP_S3 = 16'h0F80;
  localparam logic [15:0] EXP_A2 = 16'h1500;
`else
  localparam logic [15:0] EXP_S2 = 16'h0000;
  localparam logic [15:0] EXP_S3 = 16'h0C80;
  localparam logic [15:0] EXP_A2 = 16'h1800;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        rd_ack = 1'b0;
  logic [15:0] rd_data = 16'h0;
  logic        rd_req, data_valid, timeout_err, neg_flag, busy;
  logic [15:0] data_out;
  logic [7:0]  sample_cnt;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  temp_read_sched #(.SAMPLE_DIV(32'd8), .TIMEOUT(16'd4)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .rd_req      (rd_req),
    .rd_ack      (rd_ack),
    .rd_data     (rd_data),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .timeout_err (timeout_err),
    .neg_flag    (neg_flag),
    .sample_cnt  (sample_cnt),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: accepted samples become expected words in arrival order
  typedef struct packed {
    logic [15:0] data;
    logic        neg;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] m_last;
  logic        m_err;
  logic [7:0]  m_cnt;
  int          m_win[4];
  bit          m_fill;
  int          req_run;

  function automatic int half_degrees(input logic [15:0] raw);
    if (raw[15]) return 0;
    return int'(raw) / 128;
  endfunction

  task automatic model_accept(input logic [15:0] raw);
    int h;
    int v;
    exp_t x;
    h = half_degrees(raw);
`ifdef TEMP_SCHED_AVG_EN
    if (!m_fill) begin
      for (int i = 0; i < 4; i++) m_win[i] = h;
      m_fill = 1'b1;
    end else begin
      for (int i = 3; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = h;
    end
    v = (m_win[0] + m_win[1] + m_win[2] + m_win[3]) / 4;
`else
    v = h;
`endif
    m_cnt  = m_cnt + 8'd1;
    x.data = 16'(v * 128);
    x.neg  = raw[15];
    x.cnt  = m_cnt;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_last  = 16'h0;
      m_err   = 1'b0;
      m_cnt   = 8'h0;
      m_fill  = 1'b0;
      req_run = 0;
      for (int i = 0; i < 4; i++) m_win[i] = 0;
    end else begin
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          chk("valid_without_sample", data_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("mon_data", data_out, e.data);
          chk("mon_neg", neg_flag, e.neg);
          chk("mon_cnt", sample_cnt, e.cnt);
          m_last = e.data;
          m_err  = 1'b0;
        end
      end else begin
        chk("mon_data_hold", data_out, m_last);
      end
      chk("mon_timeout_err", timeout_err, m_err);
      if (rd_req) begin
        req_run++;
        chk("mon_req_len_bound", req_run <= TO, 1'b1);
        if (rd_ack) model_accept(rd_data);
        else if (req_run == TO) m_err = 1'b1;
      end else begin
        req_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input int ack_at, input logic [15:0] d);
    for (int c = 1; c < ack_at; c++) tick();
    rd_ack = 1'b1;
    rd_data = d;
    tick();
    rd_ack = 1'b0;
  endtask

  task automatic wait_req_rise(output int n);
    n = 0;
    while (!rd_req && n < 100) begin
      tick();
      n++;
    end
    if (!rd_req) chk("req_rise_timeout", rd_req, 1'b1);
  endtask

  task automatic count_high(output int h);
    h = 0;
    while (rd_req && h < 20) begin
      h++;
      tick();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_req"}, rd_req, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_valid"}, data_valid, 1'b0);
    chk({tag, "_data"}, data_out, 16'h0);
    chk({tag, "_cnt"}, sample_cnt, 8'h0);
    chk({tag, "_err"}, timeout_err, 1'b0);
    chk({tag, "_neg"}, neg_flag, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int h;
    repeat (3) tick();
    chk_all_zero("reset");

    rst = 1'b0;
    enable = 1'b1;
    tick();
    chk("first_req_no_delay", rd_req, 1'b1);
    serve(3, 16'h1980);
    chk("req_drop_after_ack", rd_req, 1'b0);
    tick();
    chk("s1_valid", data_valid, 1'b1);
    chk("s1_data", data_out, 16'h1980);
    chk("s1_cnt", sample_cnt, 8'd1);
    chk("s1_busy", busy, 1'b1);
    tick();
    chk("s1_single_pulse", data_valid, 1'b0);
    wait_req_rise(n);
    chk("wait_interval", n + 1, 8);

    count_high(h);
    chk("timeout_req_len", h, TO);
    chk("timeout_flag", timeout_err, 1'b1);
    chk("timeout_hold", data_out, 16'h1980);
    chk("timeout_cnt", sample_cnt, 8'd1);
    rd_ack = 1'b1;
    rd_data = 16'h7F80;
    tick();
    rd_ack = 1'b0;
    wait_req_rise(n);
    chk("wait_after_timeout", n + 1, 8);

    serve(1, 16'hFF80);
    tick();
    chk("s2_valid", data_valid, 1'b1);
    chk("s2_data", data_out, EXP_S2);
    chk("s2_neg", neg_flag, 1'b1);
    chk("s2_err_cleared", timeout_err, 1'b0);
    chk("s2_cnt", sample_cnt, 8'd2);

    wait_req_rise(n);
    chk("wait_s2", n, 8);
    count_high(h);
    chk("timeout2_req_len", h, TO);
    wait_req_rise(n);
    serve(4, 16'h0C80);
    tick();
    chk("s3_valid", data_valid, 1'b1);
    chk("s3_data", data_out, EXP_S3);
    chk("s3_neg", neg_flag, 1'b0);
    chk("s3_err", timeout_err, 1'b0);
    chk("s3_cnt", sample_cnt, 8'd3);

    wait_req_rise(n);
    tick();
    rst = 1'b1;
    enable = 1'b0;
    rd_ack = 1'b1;
    rd_data = 16'h1980;
    tick();
    rd_ack = 1'b0;
    chk_all_zero("rst_mid_req");
    tick();
    chk("rst_no_valid", data_valid, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle_after_rst", busy, 1'b0);

    enable = 1'b1;
    tick();
    serve(1, 16'h1400);
    tick();
    chk("a1_data", data_out, 16'h1400);
    wait_req_rise(n);
    enable = 1'b0;
    serve(2, 16'h1800);
    tick();
    chk("a2_valid", data_valid, 1'b1);
    chk("a2_data", data_out, EXP_A2);
    chk("a2_idle_after_latch", busy, 1'b0);

    enable = 1'b1;
    tick();
    chk("restart_req", rd_req, 1'b1);
    serve(1, 16'h1400);
    repeat (3) tick();
    enable = 1'b0;
    tick();
    chk("wait_exit_busy", busy, 1'b0);
    repeat (12) tick();
    chk("idle_no_req", rd_req, 1'b0);
    chk("pending_samples", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/temp_read_sched.md
TEMP_READ_SCHED -- requirements
Module: temp_read_sched

Interface
REQ-001 Parameter SAMPLE_DIV, default 50000000, SHALL set the WAIT-state length in clk cycles between reads (legal range 2..2^32-1).
REQ-002 Parameter TIMEOUT, default 1000, SHALL set the max cycles rd_req stays high awaiting rd_ack (legal range 2..65535).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port enable  input  1  high = periodic sampling runs; low = return to IDLE.
REQ-006 Port rd_req  output  1  read request to sensor interface; level, held until ack or timeout.
REQ-007 Port rd_ack  input  1  one-cycle sensor acknowledge; rd_data valid in the same cycle.
REQ-008 Port rd_data  input  16  raw sensor word: [15] sign, [14:8] integer degrees, [7] half degree.
REQ-009 Port data_out  output  16  conditioned word for the temperature converter; [15]=0, [6:0]=0.
REQ-010 Port data_valid  output  1  one-cycle pulse when data_out updates.
REQ-011 Port timeout_err  output  1  sticky flag: last request timed out.
REQ-012 Port neg_flag  output  1  last accepted sample was negative and was clamped.
REQ-013 Port sample_cnt  output  8  count of accepted samples, wraps 255->0.
REQ-014 Port busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM SHALL have states IDLE, REQ, LATCH, WAIT.
REQ-016 IDLE->REQ on enable=1; the first read is issued with no interval delay.
REQ-017 REQ: rd_req=1; on the edge sampling rd_ack=1, rd_data SHALL be captured and the state SHALL go to LATCH; rd_req SHALL drop the next cycle.
REQ-018 REQ timeout: after TIMEOUT cycles in REQ without ack -> WAIT, timeout_err<=1, data_out unchanged, no data_valid.
REQ-019 rd_ack and the timeout expiring in the same cycle: ack SHALL win (sample accepted, no error).
REQ-020 rd_ack outside REQ SHALL be ignored.
REQ-021 LATCH (1 cycle): data_out SHALL be written, data_valid=1 for exactly that following cycle, sample_cnt+1, timeout_err<=0, then WAIT.
REQ-022 Conditioning: if the captured [15]=1, the half-degree value SHALL be 0 and neg_flag=1; otherwise the half-degree value = captured [14:7] and neg_flag=0.
REQ-023 data_out SHALL be {1'b0, value[7:0], 7'b0}.
REQ-024 WAIT SHALL last exactly SAMPLE_DIV cycles, then go to REQ.
REQ-025 enable=0 in WAIT -> IDLE next cycle; enable=0 in REQ or LATCH -> complete the transaction (or timeout), then IDLE instead of WAIT.

Reset
REQ-026 rst=1 SHALL force IDLE, rd_req=0, data_out=0, data_valid=0, timeout_err=0, neg_flag=0, sample_cnt=0, busy=0, and clear all counters and the averaging window.
REQ-027 rst SHALL take priority over every event, including an in-flight REQ; no data_valid SHALL follow it.

Configuration
REQ-028 Macro TEMP_SCHED_AVG_EN defined: the value in REQ-023 SHALL be the 4-sample moving average (sum of 4 x 8-bit values in 10 bits, >>2 truncate) of conditioned values; the first sample after reset SHALL fill all 4 entries.
REQ-029 Macro TEMP_SCHED_AVG_EN undefined: the value in REQ-023 SHALL be the latest conditioned value; no window logic is present.

Structure
REQ-030 Shared package temp_pkg SHALL hold the state enum, TEMP_W=16 and HALF_W=8.
REQ-031 Sub-module temp_avg4 (4-entry window + adder) SHALL be instantiated only under TEMP_SCHED_AVG_EN.

Verification (SAMPLE_DIV=8, TIMEOUT=4)
REQ-032 enable=1, ack 2 cycles after rd_req, rd_data=16'h1980 -> data_out=16'h1980, one data_valid pulse, sample_cnt=1, next rd_req rise 8 cycles after WAIT entry.
REQ-033 No ack -> rd_req high exactly 4 cycles, timeout_err=1, data_out held; next good sample clears timeout_err.
REQ-034 rd_data=16'hFF80 -> data_out=16'h0000, neg_flag=1.
REQ-035 ack on the 4th REQ cycle -> sample accepted, timeout_err=0; rst asserted mid-REQ -> all outputs 0 next cycle, no data_valid.
REQ-036 With TEMP_SCHED_AVG_EN: samples 16'h1400 then 16'h1800 -> data_out 16'h1400, then 16'h1500 (40,40,40,48 -> 42 half-degrees); enable=0 in WAIT -> IDLE, busy=0 next cycle.
